// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART constants and divisor calculation helper.
//  Revision : 1.0 - initial fractional-N baud generator release
// ============================================================================
package uart_pkg;

    localparam int c_DEF_DIV_INT_W  = 16;
    localparam int c_DEF_DIV_FRAC_W = 4;
    localparam int c_DEF_OVERSAMPLE = 16;
    localparam int c_MIN_DIV_INT    = 2;

    // Rounded os-period in fixed point: clk * 2^frac_w / (baud * os).
    function automatic longint unsigned calc_div(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned os,
        input int unsigned     frac_w
    );
        longint unsigned den;
        den = baud * os;
        return ((clk_hz << frac_w) + (den >> 1)) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frac_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frac_tick
//  Brief    : Base counter with fractional accumulator producing os_tick.
//  Revision : 1.0 - initial fractional-N baud generator release
// ============================================================================
module uart_frac_tick
    import uart_pkg::*;
#(
    parameter int DIV_INT_W  = c_DEF_DIV_INT_W,
    parameter int DIV_FRAC_W = c_DEF_DIV_FRAC_W
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_INT_W-1:0]  div_int,
    input  logic [DIV_FRAC_W-1:0] div_frac,
    input  logic                  clear_acc,
    output logic                  os_tick
);

    localparam int c_CNT_W = DIV_INT_W + 1;

    logic [DIV_INT_W-1:0]  w_div_int_eff;
    logic [DIV_FRAC_W:0]   w_acc_sum;
    logic                  w_carry;
    logic [c_CNT_W-1:0]    w_last;
    logic                  w_fire;

    logic [c_CNT_W-1:0]    r_cnt;
    logic [DIV_FRAC_W-1:0] r_acc;
    logic                  r_os_tick;

    // The carry for the period in progress is looked up from the accumulator
    // ahead of time, so a fresh accumulator yields div_int for the first period.
    always_comb begin
        w_div_int_eff = (div_int < DIV_INT_W'(c_MIN_DIV_INT)) ? DIV_INT_W'(c_MIN_DIV_INT)
                                                              : div_int;
        w_acc_sum     = {1'b0, r_acc} + {1'b0, div_frac};
        w_carry       = w_acc_sum[DIV_FRAC_W];
        w_last        = {1'b0, w_div_int_eff} + c_CNT_W'(w_carry) - c_CNT_W'(1);
        w_fire        = (r_cnt >= w_last);
    end

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_os_tick <= 1'b0;
        end else if (!enable) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_os_tick <= 1'b0;
        end else begin
            r_os_tick <= w_fire;
            if (w_fire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (clear_acc) begin
                r_acc <= '0;
            end else if (w_fire) begin
                r_acc <= w_acc_sum[DIV_FRAC_W-1:0];
            end
        end
    end

    assign os_tick = r_os_tick;

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen_frac.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen_frac
//  Brief    : Fractional-N baud generator: os, TX-bit and RX mid-bit strobes.
//  Revision : 1.0 - initial fractional-N baud generator release
// ============================================================================
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 100000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int OVERSAMPLE   = c_DEF_OVERSAMPLE,
    parameter int DIV_INT_W    = c_DEF_DIV_INT_W,
    parameter int DIV_FRAC_W   = c_DEF_DIV_FRAC_W
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_INT_W-1:0]  cfg_div_int,
    input  logic [DIV_FRAC_W-1:0] cfg_div_frac,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  rx_resync,
    output logic                  os_tick,
    output logic                  tx_tick,
    output logic                  rx_sample_tick
);

    localparam longint unsigned   c_DEF_DIV  = calc_div(SYSTEM_CLOCK, DEFAULT_BAUD,
                                                        OVERSAMPLE, DIV_FRAC_W);
    localparam logic [DIV_INT_W-1:0]  c_DEF_INT  = DIV_INT_W'(c_DEF_DIV >> DIV_FRAC_W);
    localparam logic [DIV_FRAC_W-1:0] c_DEF_FRAC = DIV_FRAC_W'(c_DEF_DIV);
    localparam int                c_PH_W     = $clog2(OVERSAMPLE);
    localparam logic [c_PH_W-1:0] c_PH_LAST  = c_PH_W'(OVERSAMPLE - 1);
    localparam logic [c_PH_W-1:0] c_PH_MID   = c_PH_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_INT_W-1:0]  r_div_int;
    logic [DIV_FRAC_W-1:0] r_div_frac;
    logic [DIV_INT_W-1:0]  r_pend_int;
    logic [DIV_FRAC_W-1:0] r_pend_frac;
    logic                  r_pending;
    logic [c_PH_W-1:0]     r_tx_phase;
    logic [c_PH_W-1:0]     r_rx_phase;

    logic                  w_os_tick;
    logic                  w_tx_tick;
    logic                  w_accept;
    logic                  w_apply;

    uart_frac_tick #(
        .DIV_INT_W  (DIV_INT_W),
        .DIV_FRAC_W (DIV_FRAC_W)
    ) u_frac_tick (
        .system_clk (system_clk),
        .reset      (reset),
        .enable     (enable),
        .div_int    (r_div_int),
        .div_frac   (r_div_frac),
        .clear_acc  (w_apply),
        .os_tick    (w_os_tick)
    );

    // While running, a new divisor is swapped in only on a bit boundary so the
    // bit in flight keeps its original length.
    always_comb begin
        w_tx_tick = w_os_tick && (r_tx_phase == c_PH_LAST);
        w_accept  = cfg_valid && !r_pending;
        w_apply   = r_pending && (enable ? w_tx_tick : 1'b1);
    end

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            r_div_int   <= c_DEF_INT;
            r_div_frac  <= c_DEF_FRAC;
            r_pend_int  <= '0;
            r_pend_frac <= '0;
            r_pending   <= 1'b0;
        end else if (w_apply) begin
            r_div_int   <= r_pend_int;
            r_div_frac  <= r_pend_frac;
            r_pending   <= 1'b0;
        end else if (w_accept) begin
            r_pend_int  <= cfg_div_int;
            r_pend_frac <= cfg_div_frac;
            r_pending   <= 1'b1;
        end
    end

    always_ff @(posedge system_clk) begin
        if (!reset || !enable) begin
            r_tx_phase <= '0;
        end else if (w_os_tick) begin
            r_tx_phase <= (r_tx_phase == c_PH_LAST) ? '0 : r_tx_phase + c_PH_W'(1);
        end
    end

    // A resync coinciding with an os_tick swallows that tick.
    always_ff @(posedge system_clk) begin
        if (!reset || !enable || rx_resync) begin
            r_rx_phase <= '0;
        end else if (w_os_tick) begin
            r_rx_phase <= (r_rx_phase == c_PH_LAST) ? '0 : r_rx_phase + c_PH_W'(1);
        end
    end

    assign cfg_ready      = !r_pending;
    assign os_tick        = w_os_tick;
    assign tx_tick        = w_tx_tick;
    assign rx_sample_tick = w_os_tick && !rx_resync && (r_rx_phase == c_PH_MID);

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen_frac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_baud_gen_frac
//  Brief    : Directed self-checking bench for uart_baud_gen_frac.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_baud_gen_frac;

    logic        system_clk = 1'b0;
    logic        reset      = 1'b0;
    logic        enable     = 1'b0;
    logic [15:0] cfg_div_int  = '0;
    logic [3:0]  cfg_div_frac = '0;
    logic        cfg_valid  = 1'b0;
    logic        cfg_ready;
    logic        rx_resync  = 1'b0;
    logic        os_tick;
    logic        tx_tick;
    logic        rx_sample_tick;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int os_q[$];
    int tx_q[$];
    int rx_q[$];

    typedef struct {
        int di;
        int df;
        int first;
        int p2;
        int p3;
        int p4;
        int p5;
        int tx_first;
        int tx_sp;
    } vec_t;

    vec_t vecs[6];

    uart_baud_gen_frac dut (
        .system_clk     (system_clk),
        .reset          (reset),
        .enable         (enable),
        .cfg_div_int    (cfg_div_int),
        .cfg_div_frac   (cfg_div_frac),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .rx_resync      (rx_resync),
        .os_tick        (os_tick),
        .tx_tick        (tx_tick),
        .rx_sample_tick (rx_sample_tick)
    );

    always #5 system_clk = ~system_clk;
    always @(posedge system_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge system_clk);
        if (os_tick)        os_q.push_back(cyc);
        if (tx_tick)        tx_q.push_back(cyc);
        if (rx_sample_tick) rx_q.push_back(cyc);
    endtask

    task automatic clear_q();
        os_q.delete();
        tx_q.delete();
        rx_q.delete();
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0:       return os_q.size();
            1:       return tx_q.size();
            default: return rx_q.size();
        endcase
    endfunction

    function automatic int qat(input int sel, input int idx);
        if (idx >= qsize(sel)) return -1;
        case (sel)
            0:       return os_q[idx];
            1:       return tx_q[idx];
            default: return rx_q[idx];
        endcase
    endfunction

    task automatic wait_for(input string what, input int sel, input int n, input int budget);
        int k;
        k = 0;
        while (qsize(sel) < n && k < budget) begin
            step();
            k++;
        end
        if (qsize(sel) < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d events required %0d", what, qsize(sel), n);
        end
    endtask

    task automatic step_until_os(input logic level, input int budget);
        int k;
        k = 0;
        while (os_tick !== level && k < budget) begin
            step();
            k++;
        end
        check("os_level_wait", int'(os_tick), int'(level));
    endtask

    initial begin
        int t0;

        vecs[0] = '{54,  4, 54, 54, 54, 55, 54, 868, 868};
        vecs[1] = '{27,  2, 27, 27, 27, 27, 27, 434, 434};
        vecs[2] = '{ 1,  0,  2,  2,  2,  2,  2,  32,  32};
        vecs[3] = '{ 0,  8,  2,  3,  2,  3,  2,  40,  40};
        vecs[4] = '{10, 15, 10, 11, 11, 11, 11, 175, 175};
        vecs[5] = '{ 3,  1,  3,  3,  3,  3,  3,  49,  49};

        // Reset state
        repeat (3) step();
        check("rst_os_tick", int'(os_tick), 0);
        check("rst_tx_tick", int'(tx_tick), 0);
        check("rst_rx_tick", int'(rx_sample_tick), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);

        // Default divisor 54.4/16, then a mid-bit reconfiguration to 27.2/16
        reset  = 1'b1;
        enable = 1'b1;
        t0 = cyc;
        clear_q();
        wait_for("def_tx1", 1, 1, 2000);
        check("def_first_os", qat(0, 0) - t0, 54);
        check("def_first_tx", qat(1, 0) - t0, 868);
        repeat (400) step();
        cfg_div_int  = 16'd27;
        cfg_div_frac = 4'd2;
        cfg_valid    = 1'b1;
        step();
        check("cfg_ready_fall", int'(cfg_ready), 0);
        cfg_div_int  = 16'd1;
        cfg_div_frac = 4'd0;
        step();
        cfg_valid = 1'b0;
        wait_for("cfg_tx2", 1, 2, 2000);
        check("old_spacing", qat(1, 1) - qat(1, 0), 868);
        check("cfg_ready_at_apply", int'(cfg_ready), 0);
        step();
        check("cfg_ready_rise", int'(cfg_ready), 1);
        wait_for("cfg_tx4", 1, 4, 2000);
        check("new_spacing_a", qat(1, 2) - qat(1, 1), 434);
        check("new_spacing_b", qat(1, 3) - qat(1, 2), 434);

        // rx_resync on a non-tick cycle
        step_until_os(1'b0, 100);
        clear_q();
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        wait_for("rs_rx2", 2, 2, 2000);
        wait_for("rs_tx2", 1, 2, 2000);
        check("rs_first_rx", qat(2, 0), qat(0, 7));
        check("rs_second_rx", qat(2, 1), qat(0, 23));
        check("rs_tx_spacing", qat(1, 1) - qat(1, 0), 434);

        // rx_resync coinciding with an os_tick
        step_until_os(1'b1, 100);
        clear_q();
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        wait_for("rs_same_rx1", 2, 1, 2000);
        check("rs_same_first_rx", qat(2, 0), qat(0, 7));

        // Drop enable one cycle before the first tick would fire
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        t0 = cyc;
        repeat (26) step();
        enable = 1'b0;
        clear_q();
        repeat (100) step();
        check("dis_no_os", qsize(0), 0);
        check("dis_no_tx", qsize(1), 0);
        enable = 1'b1;
        t0 = cyc;
        clear_q();
        wait_for("reen_tx1", 1, 1, 2000);
        check("reen_first_os", qat(0, 0) - t0, 27);
        check("reen_first_tx", qat(1, 0) - t0, 434);

        // Reset while a divisor update is pending
        cfg_div_int  = 16'd10;
        cfg_div_frac = 4'd0;
        cfg_valid    = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("pend_ready_low", int'(cfg_ready), 0);
        reset = 1'b0;
        step();
        check("rst_pend_ready", int'(cfg_ready), 1);
        check("rst_pend_os", int'(os_tick), 0);
        reset = 1'b1;
        t0 = cyc;
        clear_q();
        wait_for("rst_pend_tx2", 1, 2, 2000);
        check("rst_pend_first_os", qat(0, 0) - t0, 54);
        check("rst_pend_first_tx", qat(1, 0) - t0, 868);
        check("rst_pend_spacing", qat(1, 1) - qat(1, 0), 868);

        // Table of divisors loaded while disabled
        enable = 1'b0;
        repeat (2) step();
        for (int v = 0; v < 6; v++) begin
            cfg_div_int  = 16'(vecs[v].di);
            cfg_div_frac = 4'(vecs[v].df);
            cfg_valid    = 1'b1;
            check($sformatf("v%0d_ready_idle", v), int'(cfg_ready), 1);
            step();
            cfg_valid = 1'b0;
            check($sformatf("v%0d_ready_low", v), int'(cfg_ready), 0);
            step();
            check($sformatf("v%0d_ready_back", v), int'(cfg_ready), 1);
            enable = 1'b1;
            t0 = cyc;
            clear_q();
            wait_for($sformatf("v%0d_tx2", v), 1, 2, 2000);
            check($sformatf("v%0d_first_os", v), qat(0, 0) - t0, vecs[v].first);
            check($sformatf("v%0d_p2", v), qat(0, 1) - qat(0, 0), vecs[v].p2);
            check($sformatf("v%0d_p3", v), qat(0, 2) - qat(0, 1), vecs[v].p3);
            check($sformatf("v%0d_p4", v), qat(0, 3) - qat(0, 2), vecs[v].p4);
            check($sformatf("v%0d_p5", v), qat(0, 4) - qat(0, 3), vecs[v].p5);
            check($sformatf("v%0d_tx_first", v), qat(1, 0) - t0, vecs[v].tx_first);
            check($sformatf("v%0d_tx_sp", v), qat(1, 1) - qat(1, 0), vecs[v].tx_sp);
            enable = 1'b0;
            repeat (3) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
